// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and op-class helpers for alu_iter.
// Imported by alu_iter and alu_iter_muldiv.
package alu_pkg;

    localparam int ALU_OP_W = 5;
    typedef logic [ALU_OP_W-1:0] op_t;

    localparam op_t ALU_OP_ADD    = 5'd0;
    localparam op_t ALU_OP_SUB    = 5'd1;
    localparam op_t ALU_OP_SLL    = 5'd2;
    localparam op_t ALU_OP_SRL    = 5'd3;
    localparam op_t ALU_OP_SRA    = 5'd4;
    localparam op_t ALU_OP_XOR    = 5'd5;
    localparam op_t ALU_OP_OR     = 5'd6;
    localparam op_t ALU_OP_AND    = 5'd7;
    localparam op_t ALU_OP_SLT    = 5'd8;
    localparam op_t ALU_OP_SLTU   = 5'd9;
    localparam op_t ALU_OP_SGE    = 5'd10;
    localparam op_t ALU_OP_SGEU   = 5'd11;
    localparam op_t ALU_OP_SEQ    = 5'd12;
    localparam op_t ALU_OP_SNE    = 5'd13;
    localparam op_t ALU_OP_MUL    = 5'd16;
    localparam op_t ALU_OP_MULH   = 5'd17;
    localparam op_t ALU_OP_MULHSU = 5'd18;
    localparam op_t ALU_OP_MULHU  = 5'd19;
    localparam op_t ALU_OP_DIV    = 5'd20;
    localparam op_t ALU_OP_DIVU   = 5'd21;
    localparam op_t ALU_OP_REM    = 5'd22;
    localparam op_t ALU_OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    function automatic logic is_mul(input op_t op);
        return (op >= ALU_OP_MUL) && (op <= ALU_OP_MULHU);
    endfunction

    function automatic logic is_div(input op_t op);
        return (op >= ALU_OP_DIV) && (op <= ALU_OP_REMU);
    endfunction

    function automatic logic is_muldiv(input op_t op);
        return is_mul(op) || is_div(op);
    endfunction

    function automatic logic is_rem(input op_t op);
        return (op == ALU_OP_REM) || (op == ALU_OP_REMU);
    endfunction

    // opb selects which operand is asked about (0: a, 1: b).
    function automatic logic is_signed(input op_t op, input logic opb);
        logic s;
        s = 1'b0;
        case (op)
            ALU_OP_MULH:   s = 1'b1;
            ALU_OP_MULHSU: s = !opb;
            ALU_OP_DIV:    s = 1'b1;
            ALU_OP_REM:    s = 1'b1;
            default:       s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic is_legal(input op_t op);
        return (op <= ALU_OP_SNE) || is_muldiv(op);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative multiply/divide datapath: one shared adder, XLEN steps.
// Ports: clk, rst_n, flush_i, start_i, op_i, a_i, b_i -> done_o, res_o.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            start_i,
    input  op_t             op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] res_o
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, dv_q, dv_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d, mul_q, mul_d;
    logic            neg_q, neg_d, sel_q, sel_d;

    logic            sa, sb;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN+1:0] add_a, add_b, sum;
    logic            ge;
    logic [XLEN-1:0] nhi, nlo, dres;
    logic [2*XLEN-1:0] prod;

    assign sa    = is_signed(op_i, 1'b0) & a_i[XLEN-1];
    assign sb    = is_signed(op_i, 1'b1) & b_i[XLEN-1];
    assign mag_a = sa ? -a_i : a_i;
    assign mag_b = sb ? -b_i : b_i;

    // Mul: hi += multiplicand when lo[0] set.
    // Div: {hi,lo msb} - divisor, sign bit = borrow.
    assign add_a = mul_q ? {2'b00, hi_q}
                         : {1'b0, hi_q, lo_q[XLEN-1]};
    assign add_b = mul_q ? {2'b00, dv_q & {XLEN{lo_q[0]}}}
                         : ~{2'b00, dv_q};
    assign sum   = add_a + add_b + {{(XLEN+1){1'b0}}, !mul_q};
    assign ge    = !sum[XLEN+1];

    always_comb begin
        nhi = hi_q;
        nlo = lo_q;
        if (mul_q) begin
            nhi = sum[XLEN:1];
            nlo = {sum[0], lo_q[XLEN-1:1]};
        end else begin
            nhi = ge ? sum[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            nlo = {lo_q[XLEN-2:0], ge};
        end
    end

    assign prod = neg_q ? -{nhi, nlo} : {nhi, nlo};
    assign dres = sel_q ? nhi : nlo;

    always_comb begin
        res_o = '0;
        if (mul_q) res_o = sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        else       res_o = neg_q ? -dres : dres;
    end

    assign done_o = busy_q && (cnt_q == CW'(XLEN-1));

    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        dv_d   = dv_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        mul_d  = mul_q;
        neg_d  = neg_q;
        sel_d  = sel_q;
        if (flush_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            hi_d   = '0;
            mul_d  = is_mul(op_i);
            lo_d   = is_mul(op_i) ? mag_b : mag_a;
            dv_d   = is_mul(op_i) ? mag_a : mag_b;
            sel_d  = is_mul(op_i) ? (op_i != ALU_OP_MUL) : is_rem(op_i);
            neg_d  = (is_rem(op_i)) ? sa : (sa ^ sb);
        end else if (busy_q) begin
            hi_d  = nhi;
            lo_d  = nlo;
            cnt_d = cnt_q + 1'b1;
            if (done_o) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            dv_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            mul_q  <= 1'b0;
            neg_q  <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            dv_q   <= dv_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            mul_q  <= mul_d;
            neg_q  <= neg_d;
            sel_q  <= sel_d;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// EX-stage ALU: registered simple ops plus iterative RV M-extension unit.
// Ports: in_valid/in_ready/alu_op/a/b in, out_valid/out_ready/out/illegal out, flush.
module alu_iter
    import alu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int SHAMT_WIDTH  = $clog2(XLEN),
    parameter int ALU_OP_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ALU_OP_WIDTH-1:0] alu_op,
    input  logic [XLEN-1:0]         a,
    input  logic [XLEN-1:0]         b,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out,
    output logic                    illegal
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            ill_q, ill_d;

    op_t                    op;
    logic                   accept;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [XLEN-1:0]        simple, fast_res, md_res;
    logic                   b_zero, ovf, fast, md_start, md_done;

    assign op    = op_t'(alu_op);
    assign shamt = b[SHAMT_WIDTH-1:0];

    assign in_ready = !flush && ((state_q == ST_IDLE) ||
                                 (state_q == ST_DONE && out_ready));
    assign accept   = in_valid && in_ready;

    always_comb begin
        simple = '0;
        unique case (op)
            ALU_OP_ADD:  simple = a + b;
            ALU_OP_SUB:  simple = a - b;
            ALU_OP_SLL:  simple = a << shamt;
            ALU_OP_SRL:  simple = a >> shamt;
            ALU_OP_SRA:  simple = $unsigned($signed(a) >>> shamt);
            ALU_OP_XOR:  simple = a ^ b;
            ALU_OP_OR:   simple = a | b;
            ALU_OP_AND:  simple = a & b;
            ALU_OP_SLT:  simple = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_OP_SLTU: simple = {{(XLEN-1){1'b0}}, a < b};
            ALU_OP_SGE:  simple = {{(XLEN-1){1'b0}}, $signed(a) >= $signed(b)};
            ALU_OP_SGEU: simple = {{(XLEN-1){1'b0}}, a >= b};
            ALU_OP_SEQ:  simple = {{(XLEN-1){1'b0}}, a == b};
            ALU_OP_SNE:  simple = {{(XLEN-1){1'b0}}, a != b};
            default:     simple = '0;
        endcase
    end

    // Divide cases whose result is known without iterating.
    assign b_zero   = (b == '0);
    assign ovf      = is_signed(op, 1'b0) &&
                      (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign fast     = is_div(op) && (b_zero || ovf);
    assign fast_res = b_zero ? (is_rem(op) ? a : '1)
                             : (is_rem(op) ? '0 : a);

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        ill_d    = ill_q;
        md_start = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_MUL, ST_DIV: begin
                    if (md_done) begin
                        state_d = ST_DONE;
                        out_d   = md_res;
                        ill_d   = 1'b0;
                    end
                end
                default: begin
                    if (state_q == ST_DONE && out_ready) state_d = ST_IDLE;
                    if (accept) begin
                        state_d = ST_DONE;
                        ill_d   = 1'b0;
                        priority case (1'b1)
                            !is_legal(op): begin
                                out_d = '0;
                                ill_d = 1'b1;
                            end
                            fast: out_d = fast_res;
                            is_muldiv(op): begin
                                md_start = 1'b1;
                                state_d  = is_mul(op) ? ST_MUL : ST_DIV;
                            end
                            default: out_d = simple;
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ill_q   <= ill_d;
        end
    end

    alu_iter_muldiv #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .start_i (md_start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .done_o  (md_done),
        .res_o   (md_res)
    );

    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter (XLEN=32).
// Checks latency, handshake, back-pressure, flush and async reset.
module tb_alu_iter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_op;
    logic [31:0] a, b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    alu_iter #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one op, confirm it is taken, then scramble the inputs.
    task automatic issue(input op_t op, input logic [31:0] av,
                         input logic [31:0] bv);
        alu_op   = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        #1;
        check("issue_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        alu_op   = ALU_OP_ADD;
        a        = $urandom;
        b        = $urandom;
    endtask

    // Cycles since accept until out_valid (1 = next cycle).
    task automatic wait_valid(output int k, output bit rdy_seen);
        k        = 1;
        rdy_seen = 1'b0;
        while (!out_valid && k < 60) begin
            if (in_ready) rdy_seen = 1'b1;
            step();
            k++;
        end
    endtask

    task automatic run(input string tag, input op_t op,
                       input logic [31:0] av, input logic [31:0] bv,
                       input int lat, input logic [31:0] exp,
                       input logic exp_ill);
        int k;
        bit rdy;
        issue(op, av, bv);
        wait_valid(k, rdy);
        check({tag, "_lat"}, k, lat);
        check(tag, out, exp);
        check({tag, "_ill"}, illegal, exp_ill);
        if (lat > 1) check({tag, "_busy_rdy"}, rdy, 0);
        step();
        check({tag, "_drain"}, out_valid, 0);
    endtask

    typedef struct {
        op_t         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t b2b[12] = '{
        '{ALU_OP_XOR,  32'hF0F00000, 32'h0FF0FFFF, 32'hFF00FFFF},
        '{ALU_OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001},
        '{ALU_OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF},
        '{ALU_OP_SLL,  32'h00000001, 32'h00000021, 32'h00000002},
        '{ALU_OP_SRL,  32'h80000000, 32'h0000001F, 32'h00000001},
        '{ALU_OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001},
        '{ALU_OP_SGE,  32'hFFFFFFFF, 32'h00000001, 32'h00000000},
        '{ALU_OP_SGEU, 32'hFFFFFFFF, 32'h00000001, 32'h00000001},
        '{ALU_OP_SEQ,  32'h00001234, 32'h00001234, 32'h00000001},
        '{ALU_OP_SNE,  32'h00001234, 32'h00001234, 32'h00000000},
        '{ALU_OP_OR,   32'h00000F00, 32'h000000F0, 32'h00000FF0},
        '{ALU_OP_AND,  32'h0000FF00, 32'h00000FF0, 32'h00000F00}
    };

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  k;
        bit  rdy;
        bit  seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_op    = ALU_OP_ADD;
        a         = '0;
        b         = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_ill", illegal, 0);
        check("rst_rdy", in_ready, 1);
        rst_n = 1'b1;
        step();

        run("add_wrap", ALU_OP_ADD, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 0);
        run("sra", ALU_OP_SRA, 32'h80000000, 32'h24, 1, 32'hF8000000, 0);

        // One simple op per cycle, out_ready held high.
        for (int i = 0; i < 12; i++) begin
            alu_op   = b2b[i].op;
            a        = b2b[i].a;
            b        = b2b[i].b;
            in_valid = 1'b1;
            #1;
            check($sformatf("b2b_rdy%0d", i), in_ready, 1);
            step();
            check($sformatf("b2b_val%0d", i), out_valid, 1);
            check($sformatf("b2b_out%0d", i), out, b2b[i].exp);
        end
        in_valid = 1'b0;
        step();
        check("b2b_drain", out_valid, 0);

        run("illegal", 5'd14, 32'h5, 32'h6, 1, 32'h0, 1);

        run("mulh", ALU_OP_MULH, 32'h80000000, 32'h80000000, 33,
            32'h40000000, 0);
        run("mulhsu", ALU_OP_MULHSU, 32'hFFFFFFFF, 32'h2, 33,
            32'hFFFFFFFF, 0);
        run("mulhu", ALU_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33,
            32'hFFFFFFFE, 0);
        run("mul", ALU_OP_MUL, 32'hFFFFFFFD, 32'h5, 33, 32'hFFFFFFF1, 0);

        run("div", ALU_OP_DIV, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFD, 0);
        run("rem", ALU_OP_REM, 32'hFFFFFFF9, 32'h2, 33, 32'hFFFFFFFF, 0);
        run("divu_big", ALU_OP_DIVU, 32'hFFFFFFFF, 32'h3, 33,
            32'h55555555, 0);
        run("remu", ALU_OP_REMU, 32'd100, 32'd7, 33, 32'd2, 0);
        run("divu_z", ALU_OP_DIVU, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 0);
        run("remu_z", ALU_OP_REMU, 32'd5, 32'd0, 1, 32'd5, 0);
        run("div_ovf", ALU_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1,
            32'h80000000, 0);
        run("rem_ovf", ALU_OP_REM, 32'h80000000, 32'hFFFFFFFF, 1,
            32'h0, 0);

        // Back-pressure: result held while out_ready is low.
        out_ready = 1'b0;
        issue(ALU_OP_DIVU, 32'd100, 32'd7);
        wait_valid(k, rdy);
        check("bp_lat", k, 33);
        check("bp_out", out, 14);
        alu_op   = ALU_OP_ADD;
        a        = 32'd2;
        b        = 32'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_hold_rdy", in_ready, 0);
            check("bp_hold_val", out_valid, 1);
            check("bp_hold_out", out, 14);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_rel_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_next_val", out_valid, 1);
        check("bp_next_out", out, 5);
        step();
        check("bp_drain", out_valid, 0);

        // Flush during the 10th DIVU iteration.
        issue(ALU_OP_DIVU, 32'd1000, 32'd3);
        repeat (9) step();
        flush    = 1'b1;
        in_valid = 1'b1;
        alu_op   = ALU_OP_ADD;
        a        = 32'd9;
        b        = 32'd9;
        #1;
        check("fl_rdy", in_ready, 0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_val", out_valid, 0);
        #1;
        check("fl_idle_rdy", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("fl_no_result", seen, 0);
        run("fl_after", ALU_OP_ADD, 32'd2, 32'd3, 1, 32'd5, 0);

        // Asynchronous reset in the middle of a multiply.
        issue(ALU_OP_MUL, 32'd1234, 32'd5678);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("ar_val", out_valid, 0);
        check("ar_out", out, 0);
        check("ar_ill", illegal, 0);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("ar_no_result", seen, 0);
        check("ar_out_after", out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
